// File: rtl/ddr_cmd_fsm_if.sv
// System-side and DDR-pin bundle of the DDR command sequencer.
// The FSM uses the slave modport; whoever issues requests uses master.
interface ddr_cmd_fsm_if #(
  parameter int ROW_W = 13,
  parameter int COL_W = 10,
  parameter int BA_W  = 2
);
  logic                        init_done;
  logic                        sys_req;
  logic                        sys_rw;
  logic [BA_W+ROW_W+COL_W-1:0] sys_addr;
  logic                        sys_ack;
  logic                        sys_busy;
  logic                        rd_valid;
  logic [3:0]                  cmd_state;
  logic                        ddr_cs_n;
  logic                        ddr_ras_n;
  logic                        ddr_cas_n;
  logic                        ddr_we_n;
  logic [BA_W-1:0]             ddr_ba;
  logic [ROW_W-1:0]            ddr_addr;

  modport master (
    output init_done, sys_req, sys_rw, sys_addr,
    input  sys_ack, sys_busy, rd_valid, cmd_state,
    input  ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_addr
  );

  modport slave (
    input  init_done, sys_req, sys_rw, sys_addr,
    output sys_ack, sys_busy, rd_valid, cmd_state,
    output ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_addr
  );
endinterface

// File: rtl/ddr_cmd_fsm.sv
// DDR command sequencer: ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH with tRCD/CL/tWR/tRP/tRFC timing.
// Optional macro DDR_AUTO_PRECHARGE_EN: READ/WRITE carry A10=1 and the explicit PRECHARGE state is skipped.
module ddr_cmd_fsm #(
  parameter int ROW_W        = 13,
  parameter int COL_W        = 10,
  parameter int BA_W         = 2,
  parameter int T_RCD        = 2,
  parameter int T_WR         = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8,
  parameter int CAS_LAT      = 2,
  parameter int BURST_LEN    = 4,
  parameter int REF_INTERVAL = 780
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ddr_cmd_fsm_if.slave  ctrl
);

  typedef enum logic [3:0] {
    IDLE                = 4'd0,
    ACTIVE              = 4'd1,
    WAIT_TRCD           = 4'd2,
    WRITE               = 4'd3,
    WAIT_END_OF_W_BURST = 4'd4,
    WAIT_WRITE_RECOVERY = 4'd5,
    READ                = 4'd6,
    WAIT_CAS_LAT        = 4'd7,
    WAIT_END_OF_R_BURST = 4'd8,
    PRECHARGE           = 4'd9,
    WAIT_TRP            = 4'd10,
    AUTO_REFRESH        = 4'd11,
    WAIT_TRFC           = 4'd12
  } state_e;

  localparam int CNT_W  = 16;
  localparam int REF_W  = $clog2(REF_INTERVAL + 1);
  localparam int ADDR_W = BA_W + ROW_W + COL_W;

  localparam int N_TRCD = T_RCD - 1;
  localparam int N_WB   = BURST_LEN / 2 - 1;
  localparam int N_WR   = T_WR;
  localparam int N_CL   = CAS_LAT - 1;
  localparam int N_RB   = BURST_LEN / 2;
  localparam int N_TRP  = T_RP - 1;
  localparam int N_TRFC = T_RFC - 1;

  localparam logic [ROW_W-1:0] A10_MASK = ROW_W'(1) << 10;
`ifdef DDR_AUTO_PRECHARGE_EN
  localparam logic [ROW_W-1:0] RW_A10 = A10_MASK;
`else
  localparam logic [ROW_W-1:0] RW_A10 = '0;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   sysAddr_q, sysAddr_d;
  logic [REF_W-1:0]    refCnt_q, refCnt_d;
  logic                refPending_q, refPending_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                rdValid_q, rdValid_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [ROW_W-1:0]    ddrAddr_q, ddrAddr_d;
  logic                takeReq;

  function automatic state_e trpOrIdle();
    return (N_TRP == 0) ? IDLE : WAIT_TRP;
  endfunction

  function automatic state_e afterBurst();
`ifdef DDR_AUTO_PRECHARGE_EN
    return trpOrIdle();
`else
    return PRECHARGE;
`endif
  endfunction

  // Wait states skip themselves when their count is zero, so a load is only ever N-1 with N>=1.
  function automatic logic [CNT_W-1:0] loadFor(state_e s);
    case (s)
      WAIT_TRCD:           return CNT_W'(N_TRCD - 1);
      WAIT_END_OF_W_BURST: return CNT_W'(N_WB - 1);
      WAIT_WRITE_RECOVERY: return CNT_W'(N_WR - 1);
      WAIT_CAS_LAT:        return CNT_W'(N_CL - 1);
      WAIT_END_OF_R_BURST: return CNT_W'(N_RB - 1);
      WAIT_TRP:            return CNT_W'(N_TRP - 1);
      WAIT_TRFC:           return CNT_W'(N_TRFC - 1);
      default:             return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl.init_done && refPending_q)  state_d = AUTO_REFRESH;
        else if (ctrl.init_done && ctrl.sys_req) state_d = ACTIVE;
      end
      ACTIVE:              state_d = (N_TRCD == 0) ? (rw_q ? WRITE : READ) : WAIT_TRCD;
      WAIT_TRCD:           if (cnt_q == '0) state_d = rw_q ? WRITE : READ;
      WRITE:               state_d = (N_WB == 0) ? WAIT_WRITE_RECOVERY : WAIT_END_OF_W_BURST;
      WAIT_END_OF_W_BURST: if (cnt_q == '0) state_d = WAIT_WRITE_RECOVERY;
      WAIT_WRITE_RECOVERY: if (cnt_q == '0) state_d = afterBurst();
      READ:                state_d = (N_CL == 0) ? WAIT_END_OF_R_BURST : WAIT_CAS_LAT;
      WAIT_CAS_LAT:        if (cnt_q == '0) state_d = WAIT_END_OF_R_BURST;
      WAIT_END_OF_R_BURST: if (cnt_q == '0) state_d = afterBurst();
      PRECHARGE:           state_d = trpOrIdle();
      WAIT_TRP:            if (cnt_q == '0) state_d = IDLE;
      AUTO_REFRESH:        state_d = (N_TRFC == 0) ? IDLE : WAIT_TRFC;
      WAIT_TRFC:           if (cnt_q == '0) state_d = IDLE;
      default:             state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = loadFor(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    else                    cnt_d = cnt_q;

    takeReq   = (state_q == IDLE) && (state_d == ACTIVE);
    rw_d      = takeReq ? ctrl.sys_rw   : rw_q;
    sysAddr_d = takeReq ? ctrl.sys_addr : sysAddr_q;

    // Refresh timer idles at its reload value until the DDR device is initialised.
    if (!ctrl.init_done)      refCnt_d = REF_W'(REF_INTERVAL - 1);
    else if (refCnt_q == '0)  refCnt_d = REF_W'(REF_INTERVAL - 1);
    else                      refCnt_d = refCnt_q - REF_W'(1);

    refPending_d = refPending_q;
    if (state_q == IDLE && state_d == AUTO_REFRESH) refPending_d = 1'b0;
    if (ctrl.init_done && refCnt_q == '0)           refPending_d = 1'b1;

    // Pins are decoded from the next state so each command lines up with its issuing state.
    case (state_d)
      ACTIVE:       cmd_d = 3'b011;
      READ:         cmd_d = 3'b101;
      WRITE:        cmd_d = 3'b100;
      PRECHARGE:    cmd_d = 3'b010;
      AUTO_REFRESH: cmd_d = 3'b001;
      default:      cmd_d = 3'b111;
    endcase

    ba_d      = ba_q;
    ddrAddr_d = ddrAddr_q;
    if (takeReq) begin
      ba_d      = ctrl.sys_addr[ADDR_W-1 -: BA_W];
      ddrAddr_d = ctrl.sys_addr[ROW_W+COL_W-1 -: ROW_W];
    end else if (state_d != state_q && (state_d == READ || state_d == WRITE)) begin
      ba_d      = sysAddr_q[ADDR_W-1 -: BA_W];
      ddrAddr_d = ROW_W'(sysAddr_q[COL_W-1:0]) | RW_A10;
    end else if (state_d == PRECHARGE) begin
      ddrAddr_d = A10_MASK;
    end

    ack_d     = takeReq;
    busy_d    = (state_d != IDLE);
    rdValid_d = (state_d == WAIT_END_OF_R_BURST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      sysAddr_q    <= '0;
      refCnt_q     <= REF_W'(REF_INTERVAL - 1);
      refPending_q <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      rdValid_q    <= 1'b0;
      cmd_q        <= 3'b111;
      ba_q         <= '0;
      ddrAddr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      sysAddr_q    <= sysAddr_d;
      refCnt_q     <= refCnt_d;
      refPending_q <= refPending_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      rdValid_q    <= rdValid_d;
      cmd_q        <= cmd_d;
      ba_q         <= ba_d;
      ddrAddr_q    <= ddrAddr_d;
    end
  end

  assign ctrl.cmd_state = state_q;
  assign ctrl.sys_ack   = ack_q;
  assign ctrl.sys_busy  = busy_q;
  assign ctrl.rd_valid  = rdValid_q;
  assign ctrl.ddr_cs_n  = 1'b0;
  assign ctrl.ddr_ras_n = cmd_q[2];
  assign ctrl.ddr_cas_n = cmd_q[1];
  assign ctrl.ddr_we_n  = cmd_q[0];
  assign ctrl.ddr_ba    = ba_q;
  assign ctrl.ddr_addr  = ddrAddr_q;

endmodule

// File: tb/tb_ddr_cmd_fsm.sv
// Directed bench for ddr_cmd_fsm (REF_INTERVAL shortened to 20); honours DDR_AUTO_PRECHARGE_EN.
module tb_ddr_cmd_fsm;
  logic clock = 1'b0;
  logic resetN;
  int   checkCount = 0;
  int   errorCount = 0;

`ifdef DDR_AUTO_PRECHARGE_EN
  localparam logic [23:0] WR_SEQ = 24'h0455A0;
  localparam int          WR_LEN = 5;
  localparam logic [23:0] RD_SEQ = 24'h0788A0;
  localparam int          RD_LEN = 5;
  localparam logic [12:0] A10    = 13'h400;
`else
  localparam logic [23:0] WR_SEQ = 24'h4559A0;
  localparam int          WR_LEN = 6;
  localparam logic [23:0] RD_SEQ = 24'h7889A0;
  localparam int          RD_LEN = 6;
  localparam logic [12:0] A10    = 13'h000;
`endif

  ddr_cmd_fsm_if #(.ROW_W(13), .COL_W(10), .BA_W(2)) bus ();

  ddr_cmd_fsm #(.REF_INTERVAL(20)) dut (
    .clk_i  (clock),
    .rst_ni (resetN),
    .ctrl   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    resetN        = 1'b0;
    bus.init_done = 1'b0;
    bus.sys_req   = 1'b0;
    bus.sys_rw    = 1'b0;
    bus.sys_addr  = '0;
    repeat (2) tick();
    resetN = 1'b1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [1:0] ba, input logic [12:0] row, input logic [9:0] col);
    bus.init_done = 1'b1;
    bus.sys_rw    = rw;
    bus.sys_addr  = {ba, row, col};
    bus.sys_req   = 1'b1;
  endtask

  // Steps through the remaining states after READ/WRITE; rd_valid and busy follow from the expected state.
  task automatic followSequence(input string tag, input logic [23:0] seq, input int len);
    logic [3:0] exp;
    for (int i = 0; i < len; i++) begin
      tick();
      exp = seq[4*(len-1-i) +: 4];
      checkOutput({tag, "-state"}, bus.cmd_state, exp);
      checkOutput({tag, "-rdvalid"}, bus.rd_valid, exp == 4'd8);
      checkOutput({tag, "-busy"}, bus.sys_busy, exp != 4'd0);
      checkOutput({tag, "-ack"}, bus.sys_ack, 1'b0);
      if (exp == 4'd9) begin
        checkOutput({tag, "-pre-cmd"}, {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b010);
        checkOutput({tag, "-pre-a10"}, bus.ddr_addr[10], 1'b1);
      end else begin
        checkOutput({tag, "-nop"}, {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b111);
      end
    end
  endtask

  int ackSeen, cmdSeen, busySeen;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    applyReset();
    checkOutput("rst-state", bus.cmd_state, 4'd0);
    checkOutput("rst-cmd", {bus.ddr_cs_n, bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 4'b0111);
    checkOutput("rst-ba", bus.ddr_ba, 2'd0);
    checkOutput("rst-addr", bus.ddr_addr, 13'd0);
    checkOutput("rst-ack", bus.sys_ack, 1'b0);
    checkOutput("rst-rdvalid", bus.rd_valid, 1'b0);
    checkOutput("rst-busy", bus.sys_busy, 1'b0);

    // Write burst
    applyStimulus(1'b1, 2'd1, 13'h123, 10'h045);
    tick();
    checkOutput("wr-act-state", bus.cmd_state, 4'd1);
    checkOutput("wr-act-ack", bus.sys_ack, 1'b1);
    checkOutput("wr-act-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b011);
    checkOutput("wr-act-ba", bus.ddr_ba, 2'd1);
    checkOutput("wr-act-addr", bus.ddr_addr, 13'h123);
    checkOutput("wr-act-busy", bus.sys_busy, 1'b1);
    bus.sys_req = 1'b0;
    tick();
    checkOutput("wr-trcd-state", bus.cmd_state, 4'd2);
    checkOutput("wr-trcd-ack", bus.sys_ack, 1'b0);
    checkOutput("wr-trcd-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b111);
    tick();
    checkOutput("wr-cmd-state", bus.cmd_state, 4'd3);
    checkOutput("wr-cmd-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b100);
    checkOutput("wr-cmd-ba", bus.ddr_ba, 2'd1);
    checkOutput("wr-cmd-addr", bus.ddr_addr, 13'h045 | A10);
    followSequence("wr", WR_SEQ, WR_LEN);
    tick();
    checkOutput("wr-idle-after", bus.cmd_state, 4'd0);

    // Read burst
    applyReset();
    applyStimulus(1'b0, 2'd2, 13'h0AB, 10'h3FF);
    tick();
    checkOutput("rd-act-state", bus.cmd_state, 4'd1);
    checkOutput("rd-act-ack", bus.sys_ack, 1'b1);
    checkOutput("rd-act-ba", bus.ddr_ba, 2'd2);
    checkOutput("rd-act-addr", bus.ddr_addr, 13'h0AB);
    bus.sys_req = 1'b0;
    tick();
    checkOutput("rd-trcd-state", bus.cmd_state, 4'd2);
    tick();
    checkOutput("rd-cmd-state", bus.cmd_state, 4'd6);
    checkOutput("rd-cmd-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b101);
    checkOutput("rd-cmd-ba", bus.ddr_ba, 2'd2);
    checkOutput("rd-cmd-addr", bus.ddr_addr, 13'h3FF | A10);
    checkOutput("rd-cmd-rdvalid", bus.rd_valid, 1'b0);
    followSequence("rd", RD_SEQ, RD_LEN);

    // Asynchronous reset in the middle of a write burst
    applyReset();
    applyStimulus(1'b1, 2'd3, 13'h001, 10'h002);
    tick();
    bus.sys_req = 1'b0;
    repeat (3) tick();
    checkOutput("abort-pre-state", bus.cmd_state, 4'd4);
    resetN = 1'b0;
    #1;
    checkOutput("abort-state", bus.cmd_state, 4'd0);
    checkOutput("abort-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b111);
    checkOutput("abort-busy", bus.sys_busy, 1'b0);
    tick();
    resetN = 1'b1;
    repeat (3) tick();
    checkOutput("abort-release-state", bus.cmd_state, 4'd0);
    checkOutput("abort-release-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b111);

    // Refresh expiry coinciding with a pending request
    applyReset();
    bus.init_done = 1'b1;
    bus.sys_rw    = 1'b0;
    bus.sys_addr  = {2'd0, 13'h055, 10'h011};
    repeat (20) tick();
    checkOutput("ref-pre-state", bus.cmd_state, 4'd0);
    bus.sys_req = 1'b1;
    tick();
    checkOutput("ref-state", bus.cmd_state, 4'd11);
    checkOutput("ref-cmd", {bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n}, 3'b001);
    checkOutput("ref-ack", bus.sys_ack, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("ref-trfc-state", bus.cmd_state, 4'd12);
      checkOutput("ref-trfc-ack", bus.sys_ack, 1'b0);
    end
    tick();
    checkOutput("ref-idle-state", bus.cmd_state, 4'd0);
    tick();
    checkOutput("ref-then-act", bus.cmd_state, 4'd1);
    checkOutput("ref-then-ack", bus.sys_ack, 1'b1);
    bus.sys_req = 1'b0;

    // No activity while the device is uninitialised
    applyReset();
    bus.init_done = 1'b0;
    bus.sys_req   = 1'b1;
    ackSeen = 0;
    cmdSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.sys_ack) ackSeen++;
      if ({bus.ddr_ras_n, bus.ddr_cas_n, bus.ddr_we_n} != 3'b111) cmdSeen++;
      if (bus.cmd_state != 4'd0 || bus.sys_busy) busySeen++;
    end
    checkOutput("noinit-acks", ackSeen, 0);
    checkOutput("noinit-cmds", cmdSeen, 0);
    checkOutput("noinit-busy", busySeen, 0);
    bus.init_done = 1'b1;
    tick();
    checkOutput("noinit-first-state", bus.cmd_state, 4'd1);
    checkOutput("noinit-first-ack", bus.sys_ack, 1'b1);
    bus.sys_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
